// File: rtl/divide_controller.sv
// Radix-2 restoring divide sequencer for MIPS DIV/DIVU (LO=quotient, HI=remainder).
// Ports: clock/reset, start_* request, flush, busy, result_* handshake, quotient, remainder.
module divide_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  start_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_quo;
  logic [DW-1:0]   r_dvsr;
  logic            r_signed;
  logic            r_sa;
  logic            r_sb;
  logic            r_dz;
  logic [DW-1:0]   r_q_out;
  logic [DW-1:0]   r_r_out;

  logic            w_acc;
  logic            w_last;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [DW-1:0]   w_a_mag;
  logic [DW-1:0]   w_b_mag;
  logic [DW:0]     w_sh;
  logic            w_ge;
  logic [DW-1:0]   w_diff;
  logic [DW-1:0]   w_q_fix;
  logic [DW-1:0]   w_r_fix;

  // reset gates ready so every output reads 0 while reset is held
  assign start_ready = reset & ~flush &
                       ((r_state == IDLE) |
                        ((r_state == DONE) & result_ready));
  assign w_acc        = start_valid & start_ready;
  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign quotient     = r_q_out;
  assign remainder    = r_r_out;

  assign w_a_neg = start_signed & dividend[DW-1];
  assign w_b_neg = start_signed & divisor[DW-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // the shifted partial remainder needs one extra bit before the trial subtract
  assign w_sh   = {r_rem, r_quo[DW-1]};
  assign w_ge   = (w_sh >= {1'b0, r_dvsr});
  assign w_diff = w_sh[DW-1:0] - r_dvsr;
  assign w_last = (r_cnt == CW'(DW));

  // divisor 0 leaves rem = |dividend|, so the dividend-sign fix restores the raw operand
  assign w_q_fix = r_dz ? {DW{1'b1}} :
                   ((r_signed & (r_sa ^ r_sb)) ? (~r_quo + 1'b1) : r_quo);
  assign w_r_fix = (r_signed & r_sa) ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_next = BUSY;
      BUSY: if (w_last) w_next = DONE;
      DONE: begin
        if (result_ready) w_next = w_acc ? BUSY : IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
    end else if (w_acc) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      r_dvsr   <= w_b_mag;
      r_signed <= start_signed;
      r_sa     <= w_a_neg;
      r_sb     <= w_b_neg;
      r_dz     <= (divisor == '0);
    end else if ((r_state == BUSY) && !flush) begin
      if (w_last) begin
        r_q_out <= w_q_fix;
        r_r_out <= w_r_fix;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_ge ? w_diff : w_sh[DW-1:0];
        r_quo <= {r_quo[DW-2:0], w_ge};
      end
    end
  end

endmodule

// File: tb/tb_divide_controller.sv
// Directed bench for divide_controller.
// Checks latency, sign rules, divide-by-zero, backpressure, flush and reset.
module tb_divide_controller;

  logic        clock;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic        start_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int passed;
  int total;

  divide_controller #(.DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_signed (start_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input logic s, input logic [31:0] a,
                           input logic [31:0] b, input string tag);
    @(negedge clock);
    start_valid  = 1'b1;
    start_signed = s;
    dividend     = a;
    divisor      = b;
    #1 chk({tag, "_start_ready"}, {31'b0, start_ready}, 32'd1);
    @(posedge clock);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] eq, input logic [31:0] er,
                             input string tag);
    repeat (32) @(posedge clock);
    @(negedge clock);
    chk({tag, "_rv_early"}, {31'b0, result_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_rv"}, {31'b0, result_valid}, 32'd1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
  endtask

  task automatic consume(input string tag);
    @(negedge clock);
    result_ready = 1'b1;
    @(posedge clock);
    #1 result_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_rv_drop"}, {31'b0, result_valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    passed       = 0;
    total        = 0;
    reset        = 1'b0;
    start_valid  = 1'b0;
    start_signed = 1'b0;
    dividend     = '0;
    divisor      = '0;
    flush        = 1'b0;
    result_ready = 1'b0;

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rv", {31'b0, result_valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_sr", {31'b0, start_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rel_sr", {31'b0, start_ready}, 32'd1);

    do_accept(1'b0, 32'd100, 32'd7, "divu100_7");
    @(negedge clock);
    chk("divu_busy", {31'b0, busy}, 32'd1);
    wait_result(32'h0000000E, 32'h00000002, "divu100_7");
    consume("divu100_7");

    do_accept(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    wait_result(32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
    consume("div_m7_2");

    do_accept(1'b1, 32'd7, 32'hFFFFFFFE, "div_7_m2");
    wait_result(32'hFFFFFFFD, 32'h00000001, "div_7_m2");
    consume("div_7_m2");

    do_accept(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    wait_result(32'h80000000, 32'h00000000, "div_ovf");
    consume("div_ovf");

    do_accept(1'b1, 32'hFFFFFFF6, 32'd0, "div_m10_0");
    wait_result(32'hFFFFFFFF, 32'hFFFFFFF6, "div_m10_0");
    consume("div_m10_0");

    do_accept(1'b0, 32'd1000, 32'd33, "hold");
    wait_result(32'd30, 32'd10, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("hold_rv", {31'b0, result_valid}, 32'd1);
      chk("hold_q", quotient, 32'd30);
      chk("hold_r", remainder, 32'd10);
    end
    result_ready = 1'b1;
    start_valid  = 1'b1;
    start_signed = 1'b0;
    dividend     = 32'd9;
    divisor      = 32'd3;
    #1 chk("b2b_sr", {31'b0, start_ready}, 32'd1);
    @(posedge clock);
    #1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    @(negedge clock);
    chk("b2b_rv0", {31'b0, result_valid}, 32'd0);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_result(32'd3, 32'd0, "b2b_9_3");
    consume("b2b_9_3");

    do_accept(1'b0, 32'd100, 32'd7, "flush");
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush        = 1'b1;
    start_valid  = 1'b1;
    dividend     = 32'd50;
    divisor      = 32'd5;
    #1 chk("flush_sr", {31'b0, start_ready}, 32'd0);
    @(posedge clock);
    #1;
    flush       = 1'b0;
    start_valid = 1'b0;
    @(negedge clock);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_sr_after", {31'b0, start_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) seen++;
    end
    chk("flush_no_rv", seen, 32'd0);

    do_accept(1'b0, 32'd5, 32'd0, "divu5_0");
    wait_result(32'hFFFFFFFF, 32'd5, "divu5_0");
    consume("divu5_0");

    do_accept(1'b0, 32'd1000, 32'd3, "rst_mid");
    repeat (15) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_rv", {31'b0, result_valid}, 32'd0);
    chk("mid_q", quotient, 32'd0);
    chk("mid_r", remainder, 32'd0);
    chk("mid_sr", {31'b0, start_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("mid_rel_sr", {31'b0, start_ready}, 32'd1);
    do_accept(1'b0, 32'd1, 32'd1, "divu1_1");
    wait_result(32'd1, 32'd0, "divu1_1");
    consume("divu1_1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
